// File: rtl/ev_index_pkg.sv
// ev_index_pkg
// Shared types and constants for the index gather unit (and its scatter
// counterpart): FSM state encoding, effective-address sum width, and the
// completion status record reported alongside done_valid.
package ev_index_pkg;

  // Width of an index word and of the data path to environment memory.
  localparam int IDX_W = 32;

  // Effective address is formed as a 33-bit sum so that a carry out of the
  // 32-bit index is still visible and treated as out of bounds.
  localparam int EA_W = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_IDX  = 3'd1,
    CALC    = 3'd2,
    RD_ELEM = 3'd3,
    WRITE   = 3'd4,
    FINISH  = 3'd5
  } state_t;

  typedef struct packed {
    logic skipped;
    logic oob;
  } done_status_t;

endpackage

// File: rtl/index_gather_unit_if.sv
// index_gather_unit_if
// Operation handshake and completion bundle between the instruction
// dispatcher (master) and the gather unit (slave).
//   op_valid/op_ready        : operation offer / accept (ready only when idle)
//   op_arr, op_index         : array base and immediate index or index address
//   op_index_is_addr         : index is a memory address holding the index
//   op_dest                  : destination word address
//   op_cond_en, op_cond_sel  : optional condition flag test
//   done_valid               : one-cycle completion pulse
//   done_skipped, done_oob   : completion status (never both set)
interface index_gather_unit_if #(
  parameter int ADDR_W = 8,
  parameter int NFLAGS = 8
) ();

  localparam int SEL_W = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;

  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_arr;
  logic [31:0]       op_index;
  logic              op_index_is_addr;
  logic [ADDR_W-1:0] op_dest;
  logic              op_cond_en;
  logic [SEL_W-1:0]  op_cond_sel;
  logic              done_valid;
  logic              done_skipped;
  logic              done_oob;

  modport master (
    output op_valid, op_arr, op_index, op_index_is_addr, op_dest,
           op_cond_en, op_cond_sel,
    input  op_ready, done_valid, done_skipped, done_oob
  );

  modport slave (
    input  op_valid, op_arr, op_index, op_index_is_addr, op_dest,
           op_cond_en, op_cond_sel,
    output op_ready, done_valid, done_skipped, done_oob
  );

endinterface

// File: rtl/index_ea_calc.sv
// index_ea_calc
// Combinational effective-address calculator shared by the gather and
// scatter units.
//   arr : array base address (ADDR_W)
//   a   : 32-bit index value
//   ea  : low ADDR_W bits of arr + a (element address when in bounds)
//   oob : arr + a >= 2**ADDR_W, including carry out of the 32-bit index
module index_ea_calc
  import ev_index_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] arr,
  input  logic [IDX_W-1:0]  a,
  output logic [ADDR_W-1:0] ea,
  output logic              oob
);

  logic [EA_W-1:0] sum;

  // Any set bit above the address field means the element lies past the end
  // of memory; addresses never wrap.
  always_comb begin
    sum = {{(EA_W-ADDR_W){1'b0}}, arr} + {1'b0, a};
    ea  = sum[ADDR_W-1:0];
    oob = |sum[EA_W-1:ADDR_W];
  end

endmodule

// File: rtl/index_gather_unit.sv
// index_gather_unit
// Sequential gather engine executing dest <- u32[arr + A], where A is either
// an immediate or a word read from memory. One operation at a time.
//   clk, rst_n     : clock and synchronous active-low reset
//   op             : operation handshake and completion (slave modport)
//   flags          : live condition flags, sampled only at accept
//   mem_rd_*       : read request; data returns on mem_rd_data one cycle later
//   mem_wr_*       : write port
//   busy           : operation in flight
module index_gather_unit
  import ev_index_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NFLAGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  index_gather_unit_if.slave op,
  input  logic [NFLAGS-1:0] flags,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy
);

  state_t            state;
  logic              ready_q;
  logic              done_q;
  done_status_t      status_q;
  logic [ADDR_W-1:0] arr_q;
  logic [ADDR_W-1:0] dest_q;

  logic [ADDR_W-1:0] calc_arr;
  logic [IDX_W-1:0]  calc_a;
  logic [ADDR_W-1:0] calc_ea;
  logic              calc_oob;
  logic              accept;
  logic              cond_ok;

  // The calculator sees the live operands while idle (immediate path) and the
  // latched base plus the returned index word while in CALC.
  always_comb begin
    if (state == CALC) begin
      calc_arr = arr_q;
      calc_a   = mem_rd_data;
    end else begin
      calc_arr = op.op_arr;
      calc_a   = op.op_index;
    end
  end

  index_ea_calc #(
    .ADDR_W(ADDR_W)
  ) u_ea_calc (
    .arr (calc_arr),
    .a   (calc_a),
    .ea  (calc_ea),
    .oob (calc_oob)
  );

  assign accept  = op.op_valid && ready_q;
  assign cond_ok = !op.op_cond_en || flags[op.op_cond_sel];

  // Read data is forwarded straight into the write port in WRITE, since it
  // arrives the cycle after RD_ELEM; gated so the bus is quiet otherwise.
  assign mem_wr_data     = mem_wr_en ? mem_rd_data : '0;
  assign op.op_ready     = ready_q;
  assign op.done_valid   = done_q;
  assign op.done_skipped = status_q.skipped;
  assign op.done_oob     = status_q.oob;

  // Main FSM. All outputs are registered and reflect the state being entered,
  // so read strobes and done pulses appear in the cycle of that state.
  // The condition is resolved first, so skipped and oob are exclusive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      arr_q       <= '0;
      dest_q      <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
    end else begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      done_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            arr_q    <= op.op_arr;
            dest_q   <= op.op_dest;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            status_q <= '0;
            if (!cond_ok) begin
              state            <= FINISH;
              done_q           <= 1'b1;
              status_q.skipped <= 1'b1;
            end else if (op.op_index_is_addr) begin
              state       <= RD_IDX;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= op.op_index[ADDR_W-1:0];
            end else if (calc_oob) begin
              state        <= FINISH;
              done_q       <= 1'b1;
              status_q.oob <= 1'b1;
            end else begin
              state       <= RD_ELEM;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= calc_ea;
            end
          end
        end

        RD_IDX: begin
          state <= CALC;
        end

        CALC: begin
          if (calc_oob) begin
            state        <= FINISH;
            done_q       <= 1'b1;
            status_q.oob <= 1'b1;
          end else begin
            state       <= RD_ELEM;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= calc_ea;
          end
        end

        RD_ELEM: begin
          state       <= WRITE;
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= dest_q;
          done_q      <= 1'b1;
        end

        WRITE, FINISH: begin
          state    <= IDLE;
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          status_q <= '0;
        end

        default: begin
          state    <= IDLE;
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          status_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_index_gather_unit.sv
// tb_index_gather_unit
// Directed scoreboard bench for index_gather_unit. Stimulus pushes the
// hand-computed completion into a queue; a negedge monitor pops and compares
// whenever done_valid is seen. A behavioural memory answers reads one cycle
// later and performs writes.
module tb_index_gather_unit;

  localparam int ADDR_W = 8;
  localparam int NFLAGS = 8;

  typedef struct {
    bit          skipped;
    bit          oob;
    bit          wr;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    int          lat;
    int          nrd;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    int          acc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NFLAGS-1:0] flags;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              busy;

  logic [31:0] mem [256];
  exp_t        exp_q[$];
  logic [7:0]  rd_log[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  index_gather_unit_if #(.ADDR_W(ADDR_W), .NFLAGS(NFLAGS)) bus ();

  index_gather_unit #(
    .ADDR_W(ADDR_W),
    .NFLAGS(NFLAGS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (bus),
    .flags       (flags),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural environment memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: logs reads per operation and scores each completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_log.delete();
    end else begin
      if (mem_rd_en) rd_log.push_back(mem_rd_addr);
      if (mem_rd_en && mem_wr_en) checkOutput("rd_wr_exclusive", 1, 0);
      if (mem_wr_en && !bus.done_valid) checkOutput("write_without_done", 1, 0);
      if (bus.done_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_skipped", bus.done_skipped, e.skipped);
          checkOutput("done_oob", bus.done_oob, e.oob);
          checkOutput("done_latency", cyc - e.acc, e.lat);
          checkOutput("wr_en", mem_wr_en, e.wr);
          if (e.wr) begin
            checkOutput("wr_addr", mem_wr_addr, e.wr_addr);
            checkOutput("wr_data", mem_wr_data, e.wr_data);
          end
          checkOutput("read_count", rd_log.size(), e.nrd);
          if (e.nrd >= 1 && rd_log.size() >= 1) checkOutput("read0_addr", rd_log[0], e.rd0);
          if (e.nrd >= 2 && rd_log.size() >= 2) checkOutput("read1_addr", rd_log[1], e.rd1);
        end
        rd_log.delete();
      end
    end
  end

  task automatic setMem(input logic [7:0] addr, input logic [31:0] data);
    mem[addr] <= data;
  endtask

  task automatic waitIdle();
    int waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.op_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || !bus.op_ready) checkOutput("idle_timeout", 0, 1);
  endtask

  // Offers one operation once the unit is ready and, when asked, pushes the
  // expected completion. Returns at the negedge of the cycle after accept.
  task automatic applyStimulus(
    input logic [7:0]  arr, input logic [31:0] idx, input bit is_addr,
    input logic [7:0]  dest, input bit cond_en, input logic [2:0] sel,
    input bit push, input bit e_skip, input bit e_oob, input logic [31:0] e_data,
    input int e_lat, input int e_nrd, input logic [7:0] e_rd0, input logic [7:0] e_rd1);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!bus.op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.op_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    bus.op_valid         = 1'b1;
    bus.op_arr           = arr;
    bus.op_index         = idx;
    bus.op_index_is_addr = is_addr;
    bus.op_dest          = dest;
    bus.op_cond_en       = cond_en;
    bus.op_cond_sel      = sel;
    if (push) begin
      e.skipped = e_skip;
      e.oob     = e_oob;
      e.wr      = !e_skip && !e_oob;
      e.wr_addr = dest;
      e.wr_data = e_data;
      e.lat     = e_lat;
      e.nrd     = e_nrd;
      e.rd0     = e_rd0;
      e.rd1     = e_rd1;
      e.acc     = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    rst_n                = 1'b0;
    flags                = '0;
    bus.op_valid         = 1'b0;
    bus.op_arr           = '0;
    bus.op_index         = '0;
    bus.op_index_is_addr = 1'b0;
    bus.op_dest          = '0;
    bus.op_cond_en       = 1'b0;
    bus.op_cond_sel      = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_op_ready", bus.op_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done_valid", bus.done_valid, 0);
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_wr_en", mem_wr_en, 0);
    checkOutput("reset_rd_addr", mem_rd_addr, 0);
    rst_n = 1'b1;

    // Immediate, taken: 16 + 4 = 20.
    setMem(8'd20, 32'hDEADBEEF);
    applyStimulus(8'd16, 32'd4, 1'b0, 8'd3, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2, 1, 8'd20, 8'd0);
    waitIdle();

    // Address-indexed: mem[9]=5, 100 + 5 = 105.
    setMem(8'd9, 32'd5);
    setMem(8'd105, 32'h1234);
    applyStimulus(8'd100, 32'd9, 1'b1, 8'd7, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'h1234, 4, 2, 8'd9, 8'd105);
    waitIdle();

    // Skipped: flags[2]=0; raising it after accept must not matter.
    applyStimulus(8'd16, 32'd4, 1'b0, 8'd4, 1'b1, 3'd2,
                  1'b1, 1'b1, 1'b0, 32'h0, 1, 0, 8'd0, 8'd0);
    flags[2] = 1'b1;
    waitIdle();
    flags[2] = 1'b0;

    // Condition true: flags[5]=1, 0 + 20 = 20.
    flags[5] = 1'b1;
    applyStimulus(8'd0, 32'd20, 1'b0, 8'd50, 1'b1, 3'd5,
                  1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2, 1, 8'd20, 8'd0);
    waitIdle();
    flags[5] = 1'b0;

    // Out of bounds, immediate: 250 + 10 = 260.
    applyStimulus(8'd250, 32'd10, 1'b0, 8'd5, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b1, 32'h0, 1, 0, 8'd0, 8'd0);
    waitIdle();

    // Out of bounds through 32-bit carry: 1 + 0xFFFFFFFF.
    applyStimulus(8'd1, 32'hFFFFFFFF, 1'b0, 8'd5, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b1, 32'h0, 1, 0, 8'd0, 8'd0);
    waitIdle();

    // Last in-bounds word: 250 + 5 = 255.
    setMem(8'd255, 32'hA5A50001);
    applyStimulus(8'd250, 32'd5, 1'b0, 8'd8, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'hA5A50001, 2, 1, 8'd255, 8'd0);
    waitIdle();

    // Out of bounds, address-indexed: mem[11]=6, 250 + 6 = 256.
    setMem(8'd11, 32'd6);
    applyStimulus(8'd250, 32'd11, 1'b1, 8'd5, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b1, 32'h0, 3, 1, 8'd11, 8'd0);
    waitIdle();

    // Upper bits of an index address are ignored: reads mem[9]=5 -> 105.
    applyStimulus(8'd100, 32'h12340109, 1'b1, 8'd60, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'h1234, 4, 2, 8'd9, 8'd105);
    waitIdle();

    // dest == ea rewrites the same value.
    setMem(8'd70, 32'h77);
    applyStimulus(8'd70, 32'd0, 1'b0, 8'd70, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'h77, 2, 1, 8'd70, 8'd0);
    waitIdle();

    // Back-to-back: op2 reads what op1 just wrote.
    setMem(8'd30, 32'hCAFEF00D);
    applyStimulus(8'd30, 32'd0, 1'b0, 8'd40, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 2, 1, 8'd30, 8'd0);
    checkOutput("ready_low_while_busy", bus.op_ready, 0);
    checkOutput("busy_high", busy, 1);
    applyStimulus(8'd40, 32'd0, 1'b0, 8'd41, 1'b0, 3'd0,
                  1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 2, 1, 8'd40, 8'd0);
    waitIdle();

    // Reset while in RD_ELEM: no write, clean idle afterwards.
    setMem(8'd12, 32'h11);
    applyStimulus(8'd12, 32'd0, 1'b0, 8'd90, 1'b0, 3'd0,
                  1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 8'd0, 8'd0);
    checkOutput("in_rd_elem_rd_en", mem_rd_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_op_ready", bus.op_ready, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wr_en", mem_wr_en, 0);
    checkOutput("abort_rd_en", mem_rd_en, 0);
    checkOutput("abort_done_valid", bus.done_valid, 0);
    checkOutput("abort_wr_data", mem_wr_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    waitIdle();

    checkOutput("mem3_final", mem[3], 32'hDEADBEEF);
    checkOutput("mem7_final", mem[7], 32'h1234);
    checkOutput("mem4_untouched", mem[4], 32'h0);
    checkOutput("mem41_final", mem[41], 32'hCAFEF00D);
    checkOutput("mem90_untouched", mem[90], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
